// File: rtl/shared_instr_memory_pkg.sv
// Shared definitions for the dual-port instruction memory: error data,
// arbitration encodings and the in-flight read descriptor.
package shared_instr_memory_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int BE_W   = DATA_W / 8;

  localparam logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam logic PORT_P0 = 1'b0;
  localparam logic PORT_P1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
    logic oor;
  } rd_pipe_entry_t;

  // Word index (address[31:2]) compared against the word depth.
  function automatic logic word_out_of_range(input logic [ADDR_W-1:0] byte_addr,
                                             input int unsigned      depth);
    return ({2'b00, byte_addr[ADDR_W-1:2]} >= 32'(depth));
  endfunction

endpackage

// File: rtl/shared_instr_memory_if.sv
// Avalon-MM style slave bus used by each port of shared_instr_memory.
interface shared_instr_memory_if;
  import shared_instr_memory_pkg::*;

  logic              waitrequest;
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              readdatavalid;
  logic [DATA_W-1:0] readdata;

  modport master (
    input  waitrequest, readdatavalid, readdata,
    output write, read, address, writedata, byteenable
  );

  modport slave (
    output waitrequest, readdatavalid, readdata,
    input  write, read, address, writedata, byteenable
  );

endinterface

// File: rtl/generic_ram.sv
// Single-port RAM with byte enables and a registered read port; contents are
// not affected by any reset.
module generic_ram #(
  parameter string MEM_TYPE  = "BRAM",
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 1024,
  parameter int    ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter string INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Byte-lane write port.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (be[i]) begin
          mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  // BRAM returns the old word on a colliding write; other styles forward.
  if (MEM_TYPE == "BRAM") begin : g_read_first
    // Registered read, read-first.
    always_ff @(posedge clk) begin
      if (en) begin
        rdata_r <= mem_r[addr];
      end
    end
  end else begin : g_write_first
    logic [DATA_W-1:0] fwd_s;

    // Merge enabled write lanes into the read word.
    always_comb begin
      fwd_s = mem_r[addr];
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (we && be[i]) begin
          fwd_s[i*8 +: 8] = wdata[i*8 +: 8];
        end else begin
          fwd_s[i*8 +: 8] = mem_r[addr][i*8 +: 8];
        end
      end
    end

    // Registered read, write-first.
    always_ff @(posedge clk) begin
      if (en) begin
        rdata_r <= fwd_s;
      end
    end
  end

  if (INIT_FILE != "") begin : g_init_image
    // Image is bound to mem_r by the implementation flow.
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/shared_instr_memory.sv
// Two-port (loader + CPU fetch) instruction memory over one single-port RAM:
// request arbitration, a fixed-latency read return pipeline and error capture.
module shared_instr_memory
  import shared_instr_memory_pkg::*;
#(
  parameter int    NUM_BYTES  = 131072,
  parameter int    RD_LATENCY = 1,
  parameter int    ARB_MODE   = 0,
  parameter string INIT_FILE  = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  shared_instr_memory_if.slave p0,
  shared_instr_memory_if.slave p1,
  output logic                 err_flag,
  output logic [ADDR_W-1:0]    err_addr,
  input  logic                 err_clr
);

  localparam int DEPTH  = NUM_BYTES / 4;
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              req0_s;
  logic              req1_s;
  logic              gnt0_s;
  logic              gnt1_s;
  logic              accept_s;
  logic              last_gnt_r;
  logic              sel_write_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic [BE_W-1:0]   sel_be_s;
  logic              oor_s;
  logic              ram_we_s;
  logic [RAM_AW-1:0] ram_addr_s;
  logic [DATA_W-1:0] ram_rdata_s;
  logic [DATA_W-1:0] mem_data_s;
  logic [DATA_W-1:0] rd_data_s;
  rd_pipe_entry_t    pipe_r [RD_LATENCY];
  rd_pipe_entry_t    tail_s;
  logic              err_flag_r;
  logic [ADDR_W-1:0] err_addr_r;

  // Arbitration: nothing is granted in reset; last_gnt_r names the port that
  // was served most recently.
  always_comb begin
    req0_s = p0.read | p0.write;
    req1_s = p1.read | p1.write;
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0_s && req1_s) begin
      if (ARB_MODE == ARB_RR) begin
        gnt0_s = (last_gnt_r == PORT_P1);
        gnt1_s = (last_gnt_r == PORT_P0);
      end else begin
        gnt0_s = 1'b1;
        gnt1_s = 1'b0;
      end
    end else begin
      gnt0_s = req0_s;
      gnt1_s = req1_s;
    end
  end

  assign accept_s       = gnt0_s | gnt1_s;
  assign p0.waitrequest = rst | (req0_s & ~gnt0_s);
  assign p1.waitrequest = rst | (req1_s & ~gnt1_s);

  // Route the granted port's request; write wins over a simultaneous read.
  always_comb begin
    if (gnt1_s) begin
      sel_write_s = p1.write;
      sel_addr_s  = p1.address;
      sel_wdata_s = p1.writedata;
      sel_be_s    = p1.byteenable;
    end else begin
      sel_write_s = p0.write;
      sel_addr_s  = p0.address;
      sel_wdata_s = p0.writedata;
      sel_be_s    = p0.byteenable;
    end
  end

  assign oor_s      = word_out_of_range(sel_addr_s, DEPTH);
  assign ram_we_s   = accept_s & sel_write_s & ~oor_s;
  assign ram_addr_s = sel_addr_s[RAM_AW+1:2];

  generic_ram #(
    .MEM_TYPE  ("BRAM"),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (RAM_AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (accept_s),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .be    (sel_be_s),
    .wdata (sel_wdata_s),
    .rdata (ram_rdata_s)
  );

  // Last-grant pointer; reset leaves port 0 winning the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_r <= PORT_P1;
    end else if (accept_s) begin
      last_gnt_r <= gnt1_s;
    end else begin
      last_gnt_r <= last_gnt_r;
    end
  end

  // Read return pipeline: never stalls, flushed by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_r[i] <= '0;
      end
    end else begin
      pipe_r[0].valid <= accept_s & ~sel_write_s;
      pipe_r[0].port  <= gnt1_s;
      pipe_r[0].oor   <= oor_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_W-1:0] rdata_q_r;

    // Extra output register stage for the two-cycle configuration.
    always_ff @(posedge clk) begin
      rdata_q_r <= ram_rdata_s;
    end

    assign mem_data_s = rdata_q_r;
  end else begin : g_lat1
    assign mem_data_s = ram_rdata_s;
  end

  assign tail_s    = pipe_r[RD_LATENCY-1];
  assign rd_data_s = tail_s.oor ? ERR_DATA : mem_data_s;

  assign p0.readdatavalid = tail_s.valid & (tail_s.port == PORT_P0);
  assign p1.readdatavalid = tail_s.valid & (tail_s.port == PORT_P1);
  assign p0.readdata      = rd_data_s;
  assign p1.readdata      = rd_data_s;

  // Sticky error capture; clear beats a coincident error.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag_r <= 1'b0;
      err_addr_r <= 32'h0000_0000;
    end else if (err_clr) begin
      err_flag_r <= 1'b0;
      err_addr_r <= 32'h0000_0000;
    end else if (accept_s && oor_s && !err_flag_r) begin
      err_flag_r <= 1'b1;
      err_addr_r <= sel_addr_s;
    end else begin
      err_flag_r <= err_flag_r;
      err_addr_r <= err_addr_r;
    end
  end

  assign err_flag = err_flag_r;
  assign err_addr = err_addr_r;

endmodule

// File: tb/tb_shared_instr_memory.sv
// Scoreboard bench for shared_instr_memory (round-robin, two-cycle latency):
// the driver predicts grants and read results, a monitor checks returns.
module tb_shared_instr_memory;

  localparam int NUM_BYTES  = 1024;
  localparam int RD_LATENCY = 2;
  localparam int ARB_MODE   = 1;
  localparam int DEPTH      = NUM_BYTES / 4;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_clr = 1'b0;
  logic        err_flag;
  logic [31:0] err_addr;

  shared_instr_memory_if p0_if ();
  shared_instr_memory_if p1_if ();

  shared_instr_memory #(
    .NUM_BYTES  (NUM_BYTES),
    .RD_LATENCY (RD_LATENCY),
    .ARB_MODE   (ARB_MODE),
    .INIT_FILE  ("")
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .p0       (p0_if),
    .p1       (p1_if),
    .err_flag (err_flag),
    .err_addr (err_addr),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state
  exp_t        exp_q[$];
  logic [31:0] mem_m [DEPTH];
  int          last_port = 1;
  bit          exp_flag = 1'b0;
  logic [31:0] exp_addr = 32'h0;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h cyc=%0d", nm, got, want, cyc);
    end
  endtask

  function automatic req_t mk_idle();
    req_t r;
    r.rd = 1'b0; r.wr = 1'b0; r.addr = 32'h0; r.wdata = 32'h0; r.be = 4'h0;
    return r;
  endfunction

  function automatic req_t mk_rd(input logic [31:0] a);
    req_t r;
    r = mk_idle();
    r.rd = 1'b1; r.addr = a;
    return r;
  endfunction

  function automatic req_t mk_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    req_t r;
    r = mk_idle();
    r.wr = 1'b1; r.addr = a; r.wdata = d; r.be = be;
    return r;
  endfunction

  function automatic req_t mk_rand();
    req_t        r;
    int          kind;
    logic [31:0] a;
    kind = int'($urandom_range(0, 3));
    if ($urandom_range(0, 15) == 0) begin
      a = ($urandom_range(0, 1) == 0) ? 32'(NUM_BYTES) + 32'($urandom_range(0, 255)) : 32'hFFFF_FFFC;
    end else begin
      a = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
    end
    r = mk_idle();
    r.rd    = (kind == 1) || (kind == 3);
    r.wr    = (kind == 2) || (kind == 3);
    r.addr  = a;
    r.wdata = $urandom;
    r.be    = 4'($urandom_range(0, 15));
    return r;
  endfunction

  // One clock of stimulus plus the reference model's view of that clock.
  task automatic drive(input req_t r0, input req_t r1, input bit clr, input bit rst_v);
    int          gp;
    bit          q0, q1, oor;
    req_t        g;
    int unsigned word;
    @(negedge clk);
    rst = rst_v;
    err_clr = clr;
    p0_if.read = r0.rd; p0_if.write = r0.wr; p0_if.address = r0.addr;
    p0_if.writedata = r0.wdata; p0_if.byteenable = r0.be;
    p1_if.read = r1.rd; p1_if.write = r1.wr; p1_if.address = r1.addr;
    p1_if.writedata = r1.wdata; p1_if.byteenable = r1.be;
    #1;
    q0 = r0.rd || r0.wr;
    q1 = r1.rd || r1.wr;
    gp = -1;
    if (!rst_v) begin
      if (q0 && q1) gp = (ARB_MODE == 1) ? 1 - last_port : 0;
      else if (q0) gp = 0;
      else if (q1) gp = 1;
    end
    chk("waitrequest_p0", {31'h0, p0_if.waitrequest}, {31'h0, rst_v || (q0 && gp != 0)});
    chk("waitrequest_p1", {31'h0, p1_if.waitrequest}, {31'h0, rst_v || (q1 && gp != 1)});
    oor = 1'b0;
    if (rst_v) begin
      exp_q.delete();
      exp_flag  = 1'b0;
      exp_addr  = 32'h0;
      last_port = 1;
    end else begin
      if (gp >= 0) begin
        g = (gp == 0) ? r0 : r1;
        last_port = gp;
        word = g.addr >> 2;
        oor  = (word >= DEPTH);
        if (g.wr) begin
          if (!oor) begin
            for (int b = 0; b < 4; b++) begin
              if (g.be[b]) mem_m[word][8*b +: 8] = g.wdata[8*b +: 8];
            end
          end
        end else begin
          exp_q.push_back('{port: gp, data: oor ? 32'hDEAD_BEEF : mem_m[word], due: cyc + RD_LATENCY});
        end
      end
      if (clr) begin
        exp_flag = 1'b0;
        exp_addr = 32'h0;
      end else if (gp >= 0 && oor && !exp_flag) begin
        exp_flag = 1'b1;
        exp_addr = g.addr;
      end
    end
  endtask

  // Monitor: match every returned read against the scoreboard.
  initial begin
    exp_t e;
    bit   v0, v1;
    forever begin
      @(posedge clk);
      #2;
      v0 = p0_if.readdatavalid;
      v1 = p1_if.readdatavalid;
      if (v0 && v1) begin
        chk("single_valid", 32'd2, 32'd1);
      end else if (v0 || v1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", {31'h0, v1}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rd_port", {31'h0, v1}, 32'(e.port));
          chk("rd_data", v1 ? p1_if.readdata : p0_if.readdata, e.data);
          chk("rd_latency", 32'(cyc), 32'(e.due));
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        chk("missing_valid", 32'(cyc), 32'(e.due));
      end
      chk("err_flag", {31'h0, err_flag}, {31'h0, exp_flag});
      chk("err_addr", err_addr, exp_addr);
    end
  end

  initial begin
    p0_if.read = 1'b0; p0_if.write = 1'b0; p0_if.address = 32'h0;
    p0_if.writedata = 32'h0; p0_if.byteenable = 4'h0;
    p1_if.read = 1'b0; p1_if.write = 1'b0; p1_if.address = 32'h0;
    p1_if.writedata = 32'h0; p1_if.byteenable = 4'h0;

    // Requests held during reset must not be accepted
    repeat (3) drive(mk_rd(32'h0), mk_wr(32'h4, 32'h1111_2222, 4'hF), 1'b0, 1'b1);

    // Give every word a known value
    for (int w = 0; w < DEPTH; w++) drive(mk_wr(32'(w) * 32'd4, $urandom, 4'hF), mk_idle(), 1'b0, 1'b0);

    // Aligned write from p0, read back on p1
    drive(mk_wr(32'h10, 32'h1234_5678, 4'hF), mk_idle(), 1'b0, 1'b0);
    drive(mk_idle(), mk_rd(32'h10), 1'b0, 1'b0);

    // Partial byte-enable write
    drive(mk_wr(32'h0, 32'h0, 4'hF), mk_idle(), 1'b0, 1'b0);
    drive(mk_wr(32'h0, 32'hAABB_CCDD, 4'b0101), mk_idle(), 1'b0, 1'b0);
    drive(mk_rd(32'h0), mk_idle(), 1'b0, 1'b0);

    // Four cycles of contention with both ports reading
    for (int i = 0; i < 4; i++) drive(mk_rd(32'(4 * i)), mk_rd(32'(64 + 4 * i)), 1'b0, 1'b0);
    repeat (3) drive(mk_idle(), mk_idle(), 1'b0, 1'b0);

    // Out-of-range accesses and the sticky error register
    drive(mk_idle(), mk_rd(32'(NUM_BYTES + 4)), 1'b0, 1'b0);
    drive(mk_idle(), mk_rd(32'(NUM_BYTES + 64)), 1'b0, 1'b0);
    drive(mk_wr(32'(NUM_BYTES), 32'hFFFF_FFFF, 4'hF), mk_idle(), 1'b0, 1'b0);
    drive(mk_idle(), mk_idle(), 1'b1, 1'b0);
    drive(mk_rd(32'hFFFF_FFF0), mk_idle(), 1'b1, 1'b0);
    drive(mk_rd(32'h0), mk_idle(), 1'b0, 1'b0);
    repeat (3) drive(mk_idle(), mk_idle(), 1'b0, 1'b0);

    // Reset the cycle after a read is accepted; memory must survive
    drive(mk_idle(), mk_rd(32'h10), 1'b0, 1'b0);
    repeat (2) drive(mk_idle(), mk_idle(), 1'b0, 1'b1);
    repeat (3) drive(mk_idle(), mk_idle(), 1'b0, 1'b0);
    drive(mk_idle(), mk_rd(32'h10), 1'b0, 1'b0);
    drive(mk_rd(32'h0), mk_idle(), 1'b0, 1'b0);

    // Random traffic on both ports
    for (int i = 0; i < 800; i++) begin
      drive(mk_rand(), mk_rand(), $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) drive(mk_idle(), mk_idle(), 1'b0, 1'b0);
    if (exp_q.size() > 0) chk("drain_pending", 32'(exp_q.size()), 32'd0);
    drive(mk_idle(), mk_idle(), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
